// File: rtl/rca_wb_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : rca_wb_serializer
//  Purpose  : Captures one grid writeback commit (NUM_WRITE_PORTS results)
//             and drains the enabled, non-x0 results one by one onto the
//             single register-file writeback port, then pulses rca_done.
//  Revision : 1.0  initial release
// ============================================================================
module rca_wb_serializer #(
    parameter int XLEN            = 32,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int ID_W            = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            commit_valid,
    output logic                            commit_ready,
    input  logic [XLEN*NUM_WRITE_PORTS-1:0] commit_data,
    input  logic [5*NUM_WRITE_PORTS-1:0]    commit_rd_addr,
    input  logic [NUM_WRITE_PORTS-1:0]      commit_port_en,
    input  logic [ID_W-1:0]                 commit_id,
    input  logic                            flush,
    output logic                            wb_valid,
    input  logic                            wb_ack,
    output logic [4:0]                      wb_rd_addr,
    output logic [XLEN-1:0]                 wb_data,
    output logic [ID_W-1:0]                 wb_id,
    output logic                            rca_done,
    output logic [ID_W-1:0]                 rca_done_id
);

    localparam int c_IDX_W = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [NUM_WRITE_PORTS-1:0] r_pending;
    logic [NUM_WRITE_PORTS-1:0] w_pending_nxt;
    logic [NUM_WRITE_PORTS-1:0] w_commit_mask;
    logic [NUM_WRITE_PORTS-1:0] w_sel_onehot;
    logic [c_IDX_W-1:0]         w_sel_idx;
    logic                       w_capture;
    logic [XLEN-1:0]            r_data [NUM_WRITE_PORTS];
    logic [4:0]                 r_rd   [NUM_WRITE_PORTS];
    logic [ID_W-1:0]            r_id;

    // A port only needs a writeback if it is enabled and does not target x0.
    generate
        for (genvar gi = 0; gi < NUM_WRITE_PORTS; gi++) begin : g_mask
            assign w_commit_mask[gi] = commit_port_en[gi] & (commit_rd_addr[gi*5 +: 5] != 5'd0);
        end
    endgenerate

    // Pick the lowest-index pending port (descending scan, last hit wins).
    always_comb begin
        w_sel_idx    = '0;
        w_sel_onehot = '0;
        for (int i = NUM_WRITE_PORTS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel_idx       = i[c_IDX_W-1:0];
                w_sel_onehot    = '0;
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    // State and pending-mask register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // Commit capture of data, destinations and instruction id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id <= '0;
            for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
                r_data[i] <= '0;
                r_rd[i]   <= '0;
            end
        end else if (w_capture) begin
            r_id <= commit_id;
            for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
                r_data[i] <= commit_data[i*XLEN +: XLEN];
                r_rd[i]   <= commit_rd_addr[i*5 +: 5];
            end
        end
    end

    // Next-state logic and outputs; flush outranks ack and commit.
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_capture     = 1'b0;
        commit_ready  = 1'b0;
        wb_valid      = 1'b0;
        wb_rd_addr    = '0;
        wb_data       = '0;
        wb_id         = '0;
        rca_done      = 1'b0;
        rca_done_id   = '0;
        case (r_state)
            ST_IDLE: begin
                commit_ready = 1'b1;
                if (commit_valid && !flush) begin
                    w_capture     = 1'b1;
                    w_pending_nxt = w_commit_mask;
                    w_state_nxt   = (|w_commit_mask) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                wb_valid   = 1'b1;
                wb_rd_addr = r_rd[w_sel_idx];
                wb_data    = r_data[w_sel_idx];
                wb_id      = r_id;
                if (flush) begin
                    w_pending_nxt = '0;
                    w_state_nxt   = ST_IDLE;
                end else if (wb_ack) begin
                    w_pending_nxt = r_pending & ~w_sel_onehot;
                    w_state_nxt   = (|(r_pending & ~w_sel_onehot)) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DONE: begin
                // A flush landing on the completion cycle cancels the pulse.
                rca_done      = ~flush;
                rca_done_id   = r_id;
                w_pending_nxt = '0;
                w_state_nxt   = ST_IDLE;
            end
            default: begin
                w_pending_nxt = '0;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
